// File: rtl/flit_input_buffer.sv
// rtl/flit_input_buffer.sv - per-port first-word-fall-through flit queue with registered credit
//
// Purpose:
//   Absorbs flits from the link (or an earlier router stage) into a circular
//   store of DEPTH slots. It presents the oldest stored flit combinationally
//   on out/out_valid. It returns a registered in_avail credit that guarantees
//   storage for any flit sent while it is high.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in            incoming flit
//   in_valid      upstream presents a flit this cycle
//   in_avail      registered credit: a flit presented now is guaranteed a slot
//   out           oldest stored flit, zero when empty
//   out_valid     buffer holds at least one flit
//   out_avail     downstream accepts out this cycle
//   occupancy     stored flit count, 0..DEPTH
//   overflow_err  sticky: in_valid arrived while full

module flit_input_buffer #(
  parameter int FLIT_SIZE = 64,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_SIZE-1:0]       in,
  input  logic                       in_valid,
  output logic                       in_avail,
  output logic [FLIT_SIZE-1:0]       out,
  output logic                       out_valid,
  input  logic                       out_avail,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [AW:0]          count_next;
  logic                 push;
  logic                 pop;
  logic                 full;

  assign full = (count == FULL);

  // Acceptance depends only on stored count, not on in_avail, so the single
  // post-reset cycle where in_avail is still 0 does not lose a flit.
  assign push = in_valid && !full && !rst;
  assign pop  = out_valid && out_avail && !rst;

  always_comb begin
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Storage is never cleared; out is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_avail     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      // Credit is derived from the post-update count, so a flit sent against
      // in_avail=1 always finds a free slot even if nothing drains.
      in_avail <= (count_next < FULL);
      if (in_valid && full) begin
        overflow_err <= 1'b1;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out       = out_valid ? mem[rd_ptr] : '0;
  assign occupancy = count;

endmodule

// File: tb/tb_flit_input_buffer.sv
// tb/tb_flit_input_buffer.sv - randomized and directed bench for flit_input_buffer against a queue model

module tb_flit_input_buffer;

  localparam int FS    = 64;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [FS-1:0]  in;
  logic           in_valid;
  logic           in_avail;
  logic [FS-1:0]  out;
  logic           out_valid;
  logic           out_avail;
  logic [2:0]     occupancy;
  logic           overflow_err;

  flit_input_buffer #(.FLIT_SIZE(FS), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .in_valid     (in_valid),
    .in_avail     (in_avail),
    .out          (out),
    .out_valid    (out_valid),
    .out_avail    (out_avail),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue of flits plus the credit and error bits.
  logic [FS-1:0] q[$];
  logic          m_avail;
  logic          m_ovf;

  task automatic check(input string tag, input logic [FS-1:0] obs, input logic [FS-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_avail = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Drive one cycle: inputs applied after the previous edge, outputs compared
  // at the falling edge, model advanced at the rising edge. Returns at edge+1.
  task automatic cycle(input logic iv, input logic [FS-1:0] d, input logic oa, input logic r);
    bit do_pop;
    bit do_push;
    rst = r; in_valid = iv; in = d; out_avail = oa;
    @(negedge clk);
    check("out_valid", FS'(out_valid), FS'(q.size() != 0));
    check("out", out, (q.size() != 0) ? q[0] : '0);
    check("occupancy", FS'(occupancy), FS'(q.size()));
    check("in_avail", FS'(in_avail), FS'(m_avail));
    check("overflow_err", FS'(overflow_err), FS'(m_ovf));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      do_pop  = (q.size() != 0) && oa;
      do_push = iv && (q.size() < DEPTH);
      if (iv && q.size() == DEPTH) m_ovf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      m_avail = (q.size() < DEPTH);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = '0; out_avail = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset then idle
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);
    check("avail_first_cycle_after_reset", FS'(in_avail), FS'(1));
    cycle(0, '0, 0, 0);

    // Fill and drain
    for (int i = 1; i <= 4; i++) cycle(1, FS'(64'hA0 + i), 0, 0);
    check("fill_occ", FS'(occupancy), FS'(4));
    check("fill_avail", FS'(in_avail), FS'(0));
    check("fill_head", out, FS'(64'hA1));
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);
    check("drained", FS'(out_valid), FS'(0));

    // Streaming with wrap: each flit visible right after its push edge
    for (int i = 1; i <= 16; i++) begin
      cycle(1, FS'(i), 1, 0);
      check("stream_out", out, FS'(i));
      check("stream_occ", FS'(occupancy), FS'(1));
    end
    cycle(0, '0, 1, 0);

    // Simultaneous push and pop at DEPTH-1: count and credit hold
    for (int i = 1; i <= 3; i++) cycle(1, FS'(64'hB0 + i), 0, 0);
    cycle(1, FS'(64'hB5), 1, 0);
    check("pp_occ", FS'(occupancy), FS'(3));
    check("pp_avail", FS'(in_avail), FS'(1));
    check("pp_ovf", FS'(overflow_err), FS'(0));
    cycle(1, FS'(64'hB6), 0, 0);

    // Overflow violation at full
    check("full_before_ovf", FS'(occupancy), FS'(4));
    cycle(1, FS'(64'hDEAD), 0, 0);
    check("ovf_set", FS'(overflow_err), FS'(1));
    check("ovf_occ", FS'(occupancy), FS'(4));
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);
    check("ovf_sticky", FS'(overflow_err), FS'(1));

    // Reset mid-operation
    for (int i = 1; i <= 3; i++) cycle(1, FS'(64'hC0 + i), 0, 0);
    cycle(0, '0, 0, 1);
    check("mid_rst_occ", FS'(occupancy), FS'(0));
    check("mid_rst_avail", FS'(in_avail), FS'(0));
    check("mid_rst_ovf", FS'(overflow_err), FS'(0));
    cycle(1, FS'(64'h55), 0, 0);
    check("post_rst_push", out, FS'(64'h55));
    cycle(0, '0, 1, 0);

    // Randomized traffic: mostly credit-respecting, rare violations and resets
    for (int n = 0; n < 3000; n++) begin
      logic iv;
      iv = ($urandom_range(0, 99) < 60) && (m_avail || $urandom_range(0, 49) == 0);
      cycle(iv, {$urandom, $urandom}, $urandom_range(0, 99) < 55, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
